// File: rtl/ntt_core_sequencer.sv
// Frame sequencer for simple_ntt_core: loads 4 coefficients, steps the core index,
// captures each delayed core result and streams the 4 results out with a last flag.
module ntt_core_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int CORE_LATENCY = 1,
  parameter int INDEX_WIDTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  core_in0,
  output logic [DATA_WIDTH-1:0]  core_in1,
  output logic [DATA_WIDTH-1:0]  core_in2,
  output logic [DATA_WIDTH-1:0]  core_in3,
  output logic [INDEX_WIDTH-1:0] core_index,
  input  logic [DATA_WIDTH-1:0]  core_out,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(3);

  state_t                 state;
  state_t                 state_nxt;
  logic [1:0]             load_cnt;
  logic [1:0]             out_cnt;
  logic [INDEX_WIDTH-1:0] issue_cnt;
  logic                   issue_done;
  logic                   tag_vld [CORE_LATENCY];
  logic [INDEX_WIDTH-1:0] tag_idx [CORE_LATENCY];
  logic [DATA_WIDTH-1:0]  coef    [4];
  logic [DATA_WIDTH-1:0]  result  [4];

  logic in_fire;
  logic out_fire;
  logic capture;
  logic cap_last;

  assign in_fire  = (state == LOAD) && in_valid;
  assign out_fire = (state == OUT) && out_ready;
  assign capture  = (state == RUN) && tag_vld[CORE_LATENCY-1];
  assign cap_last = capture && (tag_idx[CORE_LATENCY-1] == LAST_IDX);

  assign in_ready   = (state == LOAD);
  assign busy       = (state != LOAD);
  assign out_valid  = (state == OUT);
  assign out_last   = (state == OUT) && (out_cnt == 2'd3);
  assign out_data   = (state == OUT) ? result[out_cnt] : '0;
  assign core_index = issue_cnt;
  assign core_in0   = coef[0];
  assign core_in1   = coef[1];
  assign core_in2   = coef[2];
  assign core_in3   = coef[3];

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_fire && (load_cnt == 2'd3)) state_nxt = RUN;
      RUN:     if (cap_last) state_nxt = OUT;
      OUT:     if (out_fire && (out_cnt == 2'd3)) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Tags shadow the core pipeline so each core_out lands in the slot of the index that produced it.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt   <= '0;
      out_cnt    <= '0;
      issue_cnt  <= '0;
      issue_done <= 1'b0;
      for (int k = 0; k < CORE_LATENCY; k++) begin
        tag_vld[k] <= 1'b0;
        tag_idx[k] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        coef[i]   <= '0;
        result[i] <= '0;
      end
    end else begin
      if (in_fire) begin
        coef[load_cnt] <= in_data;
        load_cnt       <= load_cnt + 2'd1;
      end
      if (state == RUN) begin
        tag_vld[0] <= !issue_done;
        tag_idx[0] <= issue_cnt;
        for (int k = 1; k < CORE_LATENCY; k++) begin
          tag_vld[k] <= tag_vld[k-1];
          tag_idx[k] <= tag_idx[k-1];
        end
        if (!issue_done) begin
          if (issue_cnt == LAST_IDX) issue_done <= 1'b1;
          else                       issue_cnt  <= issue_cnt + INDEX_WIDTH'(1);
        end
        if (capture) result[tag_idx[CORE_LATENCY-1]] <= core_out;
        if (cap_last) begin
          issue_cnt  <= '0;
          issue_done <= 1'b0;
        end
      end
      if (out_fire) out_cnt <= out_cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_ntt_core_sequencer.sv
// Bench for ntt_core_sequencer: two instances (core latency 1 and 3) each driving a
// behavioural core model; table-driven frames, corner sequences and random frames.
module tb_ntt_core_sequencer;

  localparam int DW = 32;

  typedef logic [DW-1:0] word4_t [4];
  typedef struct {
    word4_t      w;
    bit          gaps;
    bit          ovr;
    logic [31:0] ovw;
    int          stall_idx;
    int          stall_len;
    word4_t      exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid  [2];
  logic [DW-1:0] in_data   [2];
  logic          in_ready  [2];
  logic [DW-1:0] c0 [2];
  logic [DW-1:0] c1 [2];
  logic [DW-1:0] c2 [2];
  logic [DW-1:0] c3 [2];
  logic [1:0]    cidx      [2];
  logic [DW-1:0] out_data  [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic          out_last  [2];
  logic          busy      [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [DW-1:0] pipe [LAT];
    logic [DW-1:0] sel_w;

    ntt_core_sequencer #(.DATA_WIDTH(DW), .CORE_LATENCY(LAT), .INDEX_WIDTH(2)) u_dut (
      .clk(clk), .reset(reset),
      .in_data(in_data[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .core_in0(c0[g]), .core_in1(c1[g]), .core_in2(c2[g]), .core_in3(c3[g]),
      .core_index(cidx[g]), .core_out(pipe[LAT-1]),
      .out_data(out_data[g]), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_last(out_last[g]), .busy(busy[g])
    );

    // Core model: registered, LAT cycles deep, result = operand[index] + index.
    always_comb begin
      case (cidx[g])
        2'd0:    sel_w = c0[g];
        2'd1:    sel_w = c1[g];
        2'd2:    sel_w = c2[g];
        default: sel_w = c3[g];
      endcase
    end

    always_ff @(posedge clk) begin
      pipe[0] <= sel_w + DW'(cidx[g]);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic feed(input int s, input word4_t w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      bit hs;
      int n;
      if (gaps) begin
        in_valid[s] = 1'b0;
        @(negedge clk);
      end
      in_valid[s] = 1'b1;
      in_data[s]  = w[i];
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 20) begin
        hs = in_ready[s];
        @(negedge clk);
        n++;
      end
      if (!hs) chk("feed_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic run_frame(input int s, input int lat, input vec_t v);
    int r;
    feed(s, v.w, v.gaps);
    in_valid[s] = v.ovr;
    in_data[s]  = v.ovw;
    r = 0;
    while (!out_valid[s] && r < 20) begin
      chk("run_index", 32'(cidx[s]), (r < 3) ? 32'(r) : 32'd3);
      chk("run_in_ready", 32'(in_ready[s]), 32'd0);
      if (r == 0) begin
        chk("run_busy", 32'(busy[s]), 32'd1);
        chk("core_in0", c0[s], v.w[0]);
        chk("core_in1", c1[s], v.w[1]);
        chk("core_in2", c2[s], v.w[2]);
        chk("core_in3", c3[s], v.w[3]);
      end
      @(negedge clk);
      r++;
    end
    chk("run_len", 32'(r), 32'(4 + lat));
    chk("out_core_in0", c0[s], v.w[0]);
    for (int j = 0; j < 4; j++) begin
      if (j == v.stall_idx) begin
        out_ready[s] = 1'b0;
        repeat (v.stall_len) begin
          chk("stall_valid", 32'(out_valid[s]), 32'd1);
          chk("stall_data", out_data[s], v.exp[j]);
          @(negedge clk);
        end
        out_ready[s] = 1'b1;
      end
      chk("out_valid", 32'(out_valid[s]), 32'd1);
      chk("out_data", out_data[s], v.exp[j]);
      chk("out_last", 32'(out_last[s]), (j == 3) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    chk("end_valid", 32'(out_valid[s]), 32'd0);
    chk("end_busy", 32'(busy[s]), 32'd0);
    chk("end_in_ready", 32'(in_ready[s]), 32'd1);
  endtask

  function automatic vec_t mk(input logic [31:0] a, b, c, d, input bit gaps, input bit ovr,
                              input logic [31:0] ovw, input int si, input int sl,
                              input logic [31:0] e0, e1, e2, e3);
    vec_t v;
    v.w[0] = a;  v.w[1] = b;  v.w[2] = c;  v.w[3] = d;
    v.gaps = gaps; v.ovr = ovr; v.ovw = ovw;
    v.stall_idx = si; v.stall_len = sl;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  vec_t tbl [5];

  initial begin
    vec_t   v;
    bit     have_carry;
    logic [31:0] carry;

    tbl[0] = mk(1, 2, 3, 4, 0, 0, 0, -1, 0, 1, 3, 5, 7);
    tbl[1] = mk(1, 2, 3, 4, 0, 0, 0, 1, 5, 1, 3, 5, 7);
    tbl[2] = mk(5, 6, 7, 8, 1, 1, 99, -1, 0, 5, 7, 9, 11);
    tbl[3] = mk(99, 100, 101, 102, 0, 0, 0, -1, 0, 99, 101, 103, 105);
    tbl[4] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 0, 0, 3, 2,
                32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);

    for (int s = 0; s < 2; s++) begin
      in_valid[s]  = 1'b0;
      in_data[s]   = '0;
      out_ready[s] = 1'b1;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_valid", 32'(out_valid[s]), 32'd0);
      chk("rst_last", 32'(out_last[s]), 32'd0);
      chk("rst_busy", 32'(busy[s]), 32'd0);
      chk("rst_data", out_data[s], 32'd0);
      chk("rst_index", 32'(cidx[s]), 32'd0);
      chk("rst_core_in0", c0[s], 32'd0);
      chk("rst_core_in3", c3[s], 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready[0]), 32'd1);

    for (int t = 0; t < 5; t++) run_frame(0, 1, tbl[t]);

    run_frame(1, 3, tbl[0]);

    // Abort a frame in its second RUN cycle, then run a clean frame.
    v = mk(7, 8, 9, 10, 0, 0, 0, -1, 0, 0, 0, 0, 0);
    feed(0, v.w, 1'b0);
    in_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_valid", 32'(out_valid[0]), 32'd0);
    chk("abort_data", out_data[0], 32'd0);
    chk("abort_index", 32'(cidx[0]), 32'd0);
    chk("abort_core_in0", c0[0], 32'd0);
    chk("abort_in_ready", 32'(in_ready[0]), 32'd1);
    reset = 1'b0;
    run_frame(0, 1, mk(10, 20, 30, 40, 0, 0, 0, -1, 0, 10, 21, 32, 43));

    for (int s = 0; s < 2; s++) begin
      have_carry = 1'b0;
      carry      = '0;
      for (int k = 0; k < 15; k++) begin
        for (int i = 0; i < 4; i++) v.w[i] = $urandom;
        if (have_carry) v.w[0] = carry;
        for (int i = 0; i < 4; i++) v.exp[i] = v.w[i] + 32'(i);
        v.gaps      = 1'($urandom_range(0, 1));
        v.ovr       = (k < 14) && ($urandom_range(0, 1) == 1);
        v.ovw       = $urandom;
        v.stall_idx = $urandom_range(0, 4);
        v.stall_len = $urandom_range(1, 4);
        have_carry  = v.ovr;
        carry       = v.ovw;
        run_frame(s, (s == 0) ? 1 : 3, v);
      end
      in_valid[s] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ntt_core_sequencer.md
Name: ntt_core_sequencer

Overview:
- Controller that sequences one simple_ntt_core per frame of 4 coefficients.
- Input side: collects 4 words from a valid/ready input stream into a coefficient buffer.
- Core side: holds the 4 words steady on the core's input_buffer0..3, steps the core's index 0..3 and captures each output_buffer result after a fixed core latency.
- Output side: streams the 4 results out on a valid/ready interface with a last flag, then returns to loading the next frame.

Parameters:
- DATA_WIDTH, 32, width of coefficients and results.
- CORE_LATENCY, 1, cycles from core_index change to a valid core_out; legal range 1..4.
- INDEX_WIDTH, 2, width of core_index; fixed by the 4-entry frame.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  DATA_WIDTH  coefficient word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  sequencer accepts a word this cycle.
- core_in0..core_in3  output  DATA_WIDTH each  to core input_buffer0..3, registered.
- core_index  output  INDEX_WIDTH  to core index, registered.
- core_out  input  DATA_WIDTH  from core output_buffer.
- out_data  output  DATA_WIDTH  result word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  marks the 4th result of a frame.
- busy  output  1  high in RUN or OUT.

Behaviour:
- Reset values, applied on a rising edge with reset=1:
  - state=LOAD, all counters 0.
  - core_in0..3=0, core_index=0, result buffer=0.
  - out_valid=0, out_last=0, out_data=0, busy=0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-frame aborts the frame. The partial frame is discarded; no result is emitted for it.
- LOAD state:
  - in_ready=1.
  - Each handshake (in_valid & in_ready) writes in_data to core_in[load_cnt], then load_cnt increments.
  - On the 4th handshake, go to RUN with core_index=0 and in_ready=0 on the next cycle. No 5th word is accepted.
- RUN state:
  - in_ready=0, busy=1.
  - core_index = 0,1,2,3 on four consecutive cycles (issue_cnt), then holds at 3.
  - core_in0..3 stay constant throughout RUN and OUT.
  - A CORE_LATENCY-deep tag shift register tracks each issued index. When a tag exits, core_out is written to result[tag] on that edge.
  - After result[3] is captured, go to OUT.
  - RUN lasts exactly 4+CORE_LATENCY cycles.
- OUT state:
  - out_valid=1, out_data=result[out_cnt], out_last=(out_cnt==3), busy=1.
  - Data is stable while out_valid & !out_ready (stall held indefinitely).
  - On each handshake, out_cnt increments.
  - On the handshake with out_last=1, go to LOAD: out_valid=0, busy=0, in_ready=1 on the next cycle.
- No overlap between frames. Input is never accepted in RUN or OUT, so a new frame cannot corrupt the operands of the frame in flight.
- Counters are 2 bits and wrap 3->0 at frame end. Results are stored unmodified; the sequencer does no arithmetic.
- in_valid or in_data changing while in_ready=0 has no effect.
- out_ready with out_valid=0 has no effect.

Test Plan:
- Bench core model: registered, latency CORE_LATENCY, core_out = core_in[core_index] + core_index.
- Basic frame: reset, feed 1,2,3,4 back-to-back, out_ready=1 → core_in0..3 = 1,2,3,4; core_index steps 0,1,2,3; out_data = 1,3,5,7; out_last only on 7; in_ready returns 1 the cycle after.
- Backpressure: hold out_ready=0 for 5 cycles at the 2nd result → out_data holds 3 with out_valid=1; no result is lost or duplicated.
- Input gaps and overrun: in_valid toggled 1,0,1,0…, then a 5th word (99) presented in RUN → frame = first 4 words only; 99 is accepted only as word 0 of the next frame.
- CORE_LATENCY=3: same inputs as the basic frame → RUN lasts 7 cycles; outputs are still 1,3,5,7 in order.
- Reset mid-RUN: assert reset at the 2nd RUN cycle → next cycle state=LOAD, all outputs 0, in_ready=1; a following frame 10,20,30,40 produces 10,21,32,43.
- Two consecutive frames with out_ready=1: results of frame 1 then frame 2, with no out_valid between the last and first results only while in LOAD/RUN.
